// File: rtl/mm_serial_pkg.sv
// mm_serial_pkg: shared constants and types for the serial result transmitter.
package mm_serial_pkg;
  localparam int VAL_W = 40;
  localparam int LEN_W = 6;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  typedef enum logic [1:0] {FILL, SEND_LEN, SEND_VAL} state_t;
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [VAL_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/result_serial_tx_if.sv
// result_serial_tx_if: parallel result input plus one-bit serial output link.
interface result_serial_tx_if;
  import mm_serial_pkg::*;
  logic             in_valid;
  logic [VAL_W-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_value;
  logic             busy;
  modport master (output in_valid, in_data, in_last, input in_ready, out_valid, out_value, busy);
  modport slave  (input in_valid, in_data, in_last, output in_ready, out_valid, out_value, busy);
endinterface

// File: rtl/bit_len_enc.sv
// bit_len_enc: index of the highest set bit plus one; zero encodes as length 1.
module bit_len_enc
  import mm_serial_pkg::*;
(
  input  logic [VAL_W-1:0] val,
  output logic [LEN_W-1:0] len
);
  always_comb begin
    len = LEN_W'(1);
    for (int i = 1; i < VAL_W; i++)
      if (val[i]) len = LEN_W'(i + 1);
  end
endmodule

// File: rtl/result_serial_tx.sv
// result_serial_tx: buffers a group of results, then streams each as length + MSB-first value bits.
module result_serial_tx
  import mm_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  result_serial_tx_if.slave bus
);
  entry_t           buf_q [DEPTH];
  entry_t           new_ent, nxt;
  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, new_len;
  logic             out_valid_q, out_valid_d, out_value_q, out_value_d, we;

  bit_len_enc u_enc (.val(bus.in_data), .len(new_len));

  assign new_ent       = '{len: new_len, data: bus.in_data};
  assign bus.in_ready  = state_q == FILL && !rst;
  assign bus.busy      = state_q != FILL;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign we            = bus.in_ready && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      FILL: if (we) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (bus.in_last || wr_ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d  = SEND_LEN;
          rd_ptr_d = '0;
          cnt_d    = LEN_W'(5);
        end
      end
      SEND_LEN: if (cnt_q == '0) begin
        state_d = SEND_VAL;
        cnt_d   = buf_q[rd_ptr_q].len - LEN_W'(1);
      end else cnt_d = cnt_q - LEN_W'(1);
      SEND_VAL: if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
      else if (rd_ptr_q == wr_ptr_q - PTR_W'(1)) begin
        state_d  = FILL;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end else begin
        state_d  = SEND_LEN;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = LEN_W'(5);
      end
      default: state_d = FILL;
    endcase
    // the closing word of a one-word group is not in the buffer yet, so forward it
    nxt         = (state_q == FILL && wr_ptr_q == '0) ? new_ent : buf_q[rd_ptr_d];
    out_valid_d = state_d != FILL;
    out_value_d = state_d == SEND_LEN ? nxt.len[cnt_d[2:0]] :
                  state_d == SEND_VAL ? nxt.data[cnt_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
    end
  end

  always_ff @(posedge clk)
    if (we) buf_q[wr_ptr_q] <= new_ent;
endmodule

// File: tb/tb_result_serial_tx.sv
// tb_result_serial_tx: directed scenarios for the serial result transmitter.
module tb_result_serial_tx;
  logic clk, rst;
  int tests = 0, fails = 0, idle_err = 0, ready_err = 0;
  logic [1023:0] b;
  int n;

  result_serial_tx_if bus ();
  result_serial_tx dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.out_valid !== 1'b1 && bus.out_value !== 1'b0) idle_err++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [39:0] v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_last  = last;
    @(negedge clk);
  endtask

  task automatic recv(output logic [1023:0] bits, output int cnt);
    int w = 0;
    bits = '0;
    cnt  = 0;
    while (bus.out_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (w >= 200) begin
      fails++;
      $display("FAIL recv_timeout: out_valid never rose after %0d cycles", w);
    end
    while (bus.out_valid === 1'b1 && cnt < 1000) begin
      bits = {bits[1022:0], bus.out_value};
      cnt++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ready_err++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_value, bus.busy, bus.in_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000", {bus.out_valid, bus.out_value, bus.busy, bus.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    push(40'd5, 1'b1);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b110) begin
      fails++;
      $display("FAIL single5_latency: valid/busy/ready got %b want 110", {bus.out_valid, bus.busy, bus.in_ready});
    end
    recv(b, n);
    tests++;
    if (n !== 9 || b[8:0] !== 9'b000011_101) begin
      fails++;
      $display("FAIL single5_frame: got len %0d bits %b want 9 000011101", n, b[8:0]);
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single5_idle: busy/ready got %b%b want 01", bus.busy, bus.in_ready);
    end
    push(40'd0, 1'b1);
    bus.in_valid = 1'b0;
    recv(b, n);
    tests++;
    if (n !== 7 || b[6:0] !== 7'b000001_0) begin
      fails++;
      $display("FAIL single0_frame: got len %0d bits %b want 7 0000010", n, b[6:0]);
    end
    push(40'hFF_FFFF_FFFF, 1'b1);
    bus.in_valid = 1'b0;
    recv(b, n);
    tests++;
    if (n !== 46 || b[45:0] !== {6'b101000, 40'hFF_FFFF_FFFF}) begin
      fails++;
      $display("FAIL single_neg1_frame: got len %0d bits %h", n, b[45:0]);
    end
  endtask

  task automatic test_group3();
    push(40'd1, 1'b0);
    push(40'h80, 1'b0);
    push(40'hFF_FFFF_FFFF, 1'b1);
    bus.in_valid = 1'b0;
    recv(b, n);
    tests++;
    if (n !== 67) begin
      fails++;
      $display("FAIL group3_len: got %0d want 67", n);
    end
    tests++;
    if (b[66:0] !== {7'b000001_1, 14'b001000_10000000, 6'b101000, 40'hFF_FFFF_FFFF}) begin
      fails++;
      $display("FAIL group3_bits: got %h", b[66:0]);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(40'(i), 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL overflow_start: valid/ready got %b%b want 10", bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 40'd9;
    bus.in_last  = 1'b1;
    recv(b, n);
    tests++;
    if (n !== 146) begin
      fails++;
      $display("FAIL overflow_len: got %0d want 146", n);
    end
    tests++;
    if (b[145:132] !== 14'b000001_0_000001_1 || b[9:0] !== 10'b000100_1111) begin
      fails++;
      $display("FAIL overflow_bits: head %b tail %b", b[145:132], b[9:0]);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: in_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back_start: out_valid got %b want 1", bus.out_valid);
    end
    recv(b, n);
    tests++;
    if (n !== 10 || b[9:0] !== 10'b000100_1001) begin
      fails++;
      $display("FAIL back_to_back_frame: got len %0d bits %b want 10 0001001001", n, b[9:0]);
    end
  endtask

  task automatic test_mid_reset();
    push(40'd1, 1'b0);
    push(40'h80, 1'b0);
    push(40'hFF_FFFF_FFFF, 1'b1);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_value, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset_outputs: valid/value/busy got %b want 000", {bus.out_valid, bus.out_value, bus.busy});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_idle: ready/valid got %b%b want 10", bus.in_ready, bus.out_valid);
    end
    push(40'd3, 1'b1);
    bus.in_valid = 1'b0;
    recv(b, n);
    tests++;
    if (n !== 8 || b[7:0] !== 8'b000010_11) begin
      fails++;
      $display("FAIL mid_reset_next: got len %0d bits %b want 8 00001011", n, b[7:0]);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (idle_err !== 0) begin
      fails++;
      $display("FAIL idle_value_zero: %0d cycles with out_value high while idle, want 0", idle_err);
    end
    tests++;
    if (ready_err !== 0) begin
      fails++;
      $display("FAIL send_ready_busy: %0d send cycles with in_ready=1 or busy=0, want 0", ready_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_group3();
    test_overflow();
    test_mid_reset();
    repeat (3) @(negedge clk);
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
